uart_frame_arbiter: RTL and testbench

Round-robin frame scheduler that shares one `s_uart_tx` byte transmitter between `N_REQ` byte-stream requesters. It grants one requester per frame and emits each frame as sync byte, header, payload and checksum. It drives `TxD_start`/`TxD_data` and watches `TxD_busy`, so transmitter bytes never collide or get dropped. It sits between the sensor-side data producers and the single serial TX line.

---
 rtl/uart_frame_arbiter.sv | 107 ++++++++++
 tb/tb_uart_frame_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_arbiter.sv
// Round-robin frame scheduler sharing one UART byte transmitter among N_REQ byte streams.
// Each frame goes out as SYNC_BYTE, {seq, grant_id}, payload, then the XOR checksum of header and payload.
module uart_frame_arbiter #(
  parameter int         N_REQ     = 4,
  parameter int         MAX_LEN   = 64,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic               frame_active,
  output logic [3:0]         grant_id
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, SYNC, HDR, DATA, CSUM} state_t;

  state_t        state;
  logic [IW-1:0] gnt, rr_ptr, pick, rr_next;
  logic          found, open, take, at_max;
  logic [3:0]    seq;
  logic [7:0]    len, csum, gdata, hdr;

  // tx_start itself closes the slot: the UART only raises busy one cycle later
  assign open     = !tx_busy && !tx_start;
  assign grant_id = 4'(gnt);
  assign gdata    = req_data[8*gnt +: 8];
  assign take     = (state == DATA) && open && req_valid[gnt];
  assign at_max   = (len == 8'(MAX_LEN - 1));
  assign hdr      = {seq, grant_id};
  assign rr_next  = (gnt == IW'(N_REQ - 1)) ? '0 : gnt + 1'b1;

  // ready is gated by valid so it pulses once per accepted byte
  always_comb begin
    req_ready      = '0;
    req_ready[gnt] = take;
  end

  // scan downward so the nearest valid requester at or above rr_ptr wins
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[(int'(rr_ptr) + i) % N_REQ]) begin
        pick  = IW'((int'(rr_ptr) + i) % N_REQ);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      frame_active <= 1'b0;
      gnt          <= '0;
      rr_ptr       <= '0;
      seq          <= 4'h0;
      len          <= 8'h00;
      csum         <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: if (found) begin
          gnt          <= pick;
          frame_active <= 1'b1;
          state        <= SYNC;
        end
        SYNC: if (open) begin
          tx_start <= 1'b1;
          tx_data  <= SYNC_BYTE;
          state    <= HDR;
        end
        HDR: if (open) begin
          tx_start <= 1'b1;
          tx_data  <= hdr;
          csum     <= hdr;
          len      <= 8'h00;
          state    <= DATA;
        end
        DATA: if (take) begin
          tx_start <= 1'b1;
          tx_data  <= gdata;
          csum     <= csum ^ gdata;
          len      <= len + 8'd1;
          if (req_last[gnt] || at_max) state <= CSUM;
        end
        CSUM: if (open) begin
          tx_start     <= 1'b1;
          tx_data      <= csum;
          frame_active <= 1'b0;
          rr_ptr       <= rr_next;
          seq          <= seq + 4'd1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter: two instances (MAX_LEN 64 and 2) each driving a UART busy model;
// wire bytes are captured and compared against hand-computed frames.
module tb_uart_frame_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        tx_start, tx_busy, frame_active;
  logic [7:0]  tx_data;
  logic [3:0]  grant_id;

  logic [3:0]  b_req_valid, b_req_last, b_req_ready;
  logic [31:0] b_req_data;
  logic        b_tx_start, b_tx_busy, b_frame_active;
  logic [7:0]  b_tx_data;
  logic [3:0]  b_grant_id;

  uart_frame_arbiter #(.N_REQ(4), .MAX_LEN(64), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .frame_active(frame_active), .grant_id(grant_id));

  uart_frame_arbiter #(.N_REQ(4), .MAX_LEN(2), .SYNC_BYTE(8'hA5)) dut_trunc (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_data(b_req_data), .req_last(b_req_last),
    .req_ready(b_req_ready), .tx_start(b_tx_start), .tx_data(b_tx_data), .tx_busy(b_tx_busy),
    .frame_active(b_frame_active), .grant_id(b_grant_id));

  // UART model: busy rises the cycle after tx_start and lasts 11 cycles; it ignores the arbiter reset
  logic hold_busy = 1'b0;
  int   cnt_a = 0, cnt_b = 0, cyc = 0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    cnt_a <= tx_start ? 11 : (cnt_a > 0 ? cnt_a - 1 : 0);
    cnt_b <= b_tx_start ? 11 : (cnt_b > 0 ? cnt_b - 1 : 0);
  end
  assign tx_busy   = (cnt_a != 0) || hold_busy;
  assign b_tx_busy = (cnt_b != 0);

  int         errors = 0, checks = 0;
  logic [7:0] qa[$], qb[$], exp_q[$];
  int         sa[$];
  logic       prev_a = 1'b0, prev_b = 1'b0;

  always @(negedge clk) begin
    if (tx_start) begin
      qa.push_back(tx_data);
      sa.push_back(cyc);
      checks++;
      if (tx_busy || prev_a) begin
        errors++;
        $display("FAIL start_rule_a: start=1 with busy=%0b prev_start=%0b, want busy=0 prev_start=0 (cycle %0d)", tx_busy, prev_a, cyc);
      end
    end
    if (b_tx_start) begin
      qb.push_back(b_tx_data);
      checks++;
      if (b_tx_busy || prev_b) begin
        errors++;
        $display("FAIL start_rule_b: start=1 with busy=%0b prev_start=%0b, want busy=0 prev_start=0 (cycle %0d)", b_tx_busy, prev_b, cyc);
      end
    end
    prev_a = tx_start;
    prev_b = b_tx_start;
  end

  typedef struct {
    int         req;
    logic [7:0] d;
    bit         last;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
    end
  endtask

  task automatic fail(input string msg);
    checks++;
    errors++;
    $display("FAIL %s", msg);
  endtask

  task automatic set_req(input bit sel, input int r, input logic v, input logic [7:0] d, input logic last);
    if (!sel) begin
      req_valid[r] = v; req_data[8*r +: 8] = d; req_last[r] = last;
    end else begin
      b_req_valid[r] = v; b_req_data[8*r +: 8] = d; b_req_last[r] = last;
    end
  endtask

  // present one byte on requester r and hold it until the handshake edge
  task automatic push(input bit sel, input int r, input logic [7:0] d, input bit last);
    int t;
    t = 0;
    @(negedge clk);
    set_req(sel, r, 1'b1, d, last);
    #1;
    while (!(sel ? b_req_ready[r] : req_ready[r]) && t < 3000) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 3000) fail($sformatf("push_timeout req%0d byte 0x%0h: no ready, want handshake within 3000 cycles", r, d));
    else @(posedge clk);
    #1 set_req(sel, r, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic cmp_stream(input bit sel, input string nm);
    int t, n;
    t = 0;
    while (((sel ? qb.size() : qa.size()) < exp_q.size()) && t < 5000) begin
      @(negedge clk); t++;
    end
    n = sel ? qb.size() : qa.size();
    chk({nm, "_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < n) chk($sformatf("%s[%0d]", nm, i), sel ? qb[i] : qa[i], exp_q[i]);
    qa.delete(); qb.delete(); sa.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, sz, t, fall;
    logic [3:0] rdy_seen;
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    b_req_valid = '0; b_req_last = '0; b_req_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_frame_active", frame_active, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_b_frame_active", b_frame_active, 0);
    rst = 1'b0;

    // single requester, 3-byte frame; checksum 00^01^02^03 = 00
    vecs = '{'{0, 8'h01, 1'b0}, '{0, 8'h02, 1'b0}, '{0, 8'h03, 1'b1}};
    @(negedge clk);
    c0 = cyc + 1;
    fork
      for (int i = 0; i < vecs.size(); i++) push(1'b0, vecs[i].req, vecs[i].d, vecs[i].last);
      begin
        @(negedge clk); @(negedge clk); #2;
        chk("t1_frame_active_cycle1", frame_active, 1);
        chk("t1_no_start_cycle1", tx_start, 0);
      end
    join
    if (sa.size() > 0) chk("t1_first_start_cycle", sa[0], c0 + 2);
    else fail("t1_first_start_cycle: no tx_start seen, want one at valid+2");
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
    cmp_stream(1'b0, "t1_wire");
    chk("t1_frame_active_end", frame_active, 0);

    // seq advanced to 1, rr_ptr now 1
    push(1'b0, 1, 8'h55, 1'b1);
    exp_q = '{8'hA5, 8'h11, 8'h55, 8'h44};
    cmp_stream(1'b0, "t1b_wire");

    // fresh state, two competing requesters, two rounds
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    fork
      push(1'b0, 0, 8'h11, 1'b1);
      push(1'b0, 2, 8'h22, 1'b1);
    join
    exp_q = '{8'hA5, 8'h00, 8'h11, 8'h11, 8'hA5, 8'h12, 8'h22, 8'h30};
    cmp_stream(1'b0, "t2_round1");
    fork
      push(1'b0, 0, 8'h33, 1'b1);
      push(1'b0, 2, 8'h44, 1'b1);
    join
    exp_q = '{8'hA5, 8'h20, 8'h33, 8'h13, 8'hA5, 8'h32, 8'h44, 8'h76};
    cmp_stream(1'b0, "t2_round2");

    // payload stall of 100 cycles (seq 4, requester 3)
    push(1'b0, 3, 8'h5A, 1'b0);
    t = 0;
    while (qa.size() < 3 && t < 200) begin @(negedge clk); t++; end
    sz = qa.size();
    rdy_seen = '0;
    repeat (100) begin
      @(negedge clk);
      rdy_seen = rdy_seen | req_ready;
    end
    chk("t4_gap_no_start", qa.size(), sz);
    chk("t4_gap_ready", rdy_seen, 0);
    chk("t4_gap_grant", grant_id, 3);
    chk("t4_gap_active", frame_active, 1);
    push(1'b0, 3, 8'hC3, 1'b1);
    exp_q = '{8'hA5, 8'h43, 8'h5A, 8'hC3, 8'hDA};
    cmp_stream(1'b0, "t4_wire");

    // busy held externally across the SYNC decision
    hold_busy = 1'b1;
    fork
      push(1'b0, 0, 8'h01, 1'b1);
      begin
        repeat (20) @(negedge clk);
        chk("t5_held_no_start", qa.size(), 0);
        chk("t5_held_active", frame_active, 1);
        hold_busy = 1'b0;
      end
    join
    exp_q = '{8'hA5, 8'h50, 8'h01, 8'h51};
    cmp_stream(1'b0, "t5_wire");

    // reset in DATA while the UART is still sending the header
    @(negedge clk);
    set_req(1'b0, 1, 1'b1, 8'h77, 1'b0);
    t = 0;
    while (qa.size() < 2 && t < 200) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    chk("t6_busy_in_data", tx_busy, 1);
    chk("t6_active_in_data", frame_active, 1);
    rst = 1'b1;
    set_req(1'b0, 1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t6_rst_tx_start", tx_start, 0);
    chk("t6_rst_tx_data", tx_data, 0);
    chk("t6_rst_req_ready", req_ready, 0);
    chk("t6_rst_frame_active", frame_active, 0);
    chk("t6_rst_grant_id", grant_id, 0);
    rst = 1'b0;
    qa.delete(); sa.delete();
    fall = 0;
    fork
      push(1'b0, 0, 8'h0F, 1'b1);
      push(1'b0, 2, 8'hF0, 1'b1);
      begin
        t = 0;
        while (tx_busy && t < 100) begin @(negedge clk); t++; end
        fall = cyc;
      end
    join
    if (sa.size() > 0) chk("t6_sync_after_busy", sa[0], fall + 1);
    else fail("t6_sync_after_busy: no tx_start seen, want one after busy falls");
    exp_q = '{8'hA5, 8'h00, 8'h0F, 8'h0F, 8'hA5, 8'h12, 8'hF0, 8'hE2};
    cmp_stream(1'b0, "t6_wire");

    // MAX_LEN=2 instance: 5-byte stream splits into 2+2+1
    vecs = '{'{1, 8'h10, 1'b0}, '{1, 8'h20, 1'b0}, '{1, 8'h30, 1'b0}, '{1, 8'h40, 1'b0}, '{1, 8'h50, 1'b1}};
    for (int i = 0; i < vecs.size(); i++) push(1'b1, vecs[i].req, vecs[i].d, vecs[i].last);
    exp_q = '{8'hA5, 8'h01, 8'h10, 8'h20, 8'h31,
              8'hA5, 8'h11, 8'h30, 8'h40, 8'h61,
              8'hA5, 8'h21, 8'h50, 8'h71};
    cmp_stream(1'b1, "t3_trunc");

    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
